cke_sched: RTL and testbench

Multi-channel clock-enable scheduler. A shared programmable prescaler produces a base tick. Up to `pChNum` independent channels divide that tick into periodic or one-shot `oCke` pulses. Channel expirations are reported to one consumer through a round-robin arbitrated valid/ready event port. The block sits between the register block and the timing consumers (display, audio, game-tick logic), replacing per-consumer divider instances.

---
 rtl/cke_sched.sv | 147 ++++++++++++++
 tb/tb_cke_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cke_sched.sv
// Multi-channel clock-enable scheduler: shared prescaler, per-channel dividers, round-robin event port.
// Define CKE_SCHED_ONESHOT_EN to honour iChMode (one-shot channels); otherwise every channel is periodic.
module cke_sched #(
  parameter int pChNum    = 4,
  parameter int pDivWidth = 15
) (
  input  logic                            iSysClk,
  input  logic                            iSysRst,
  input  logic                            iEn,
  input  logic [pDivWidth:0]              iPreDiv,
  input  logic [pChNum*(pDivWidth+1)-1:0] iChDiv,
  input  logic [pChNum-1:0]               iChMode,
  input  logic [pChNum-1:0]               iChStart,
  input  logic [pChNum-1:0]               iChStop,
  output logic [pChNum-1:0]               oCke,
  output logic [pChNum-1:0]               oChBusy,
  output logic                            oEvtValid,
  output logic [2:0]                      oEvtCh,
  input  logic                            iEvtReady,
  output logic [pChNum-1:0]               oChOvr,
  input  logic                            iOvrClr
);

  localparam int DW = pDivWidth + 1;

  logic [pDivWidth:0] r_pre_cnt;
  logic [pDivWidth:0] r_cnt  [pChNum];
  logic [pDivWidth:0] r_shdw [pChNum];
  logic [pChNum-1:0]  r_busy, r_cke, r_pend, r_ovr;
  logic [2:0]         r_last, r_evt_ch;
  logic               r_evt_vld;

  logic               w_tick, w_acc, w_found;
  logic [2:0]         w_base, w_sel;
  logic [pChNum-1:0]  w_match, w_fire, w_oneshot, w_acc_mask, w_cand, w_ovr_set;

`ifdef CKE_SCHED_ONESHOT_EN
  logic [pChNum-1:0]  r_mode;
  assign w_oneshot = r_mode;
`else
  logic               w_unused_mode;
  assign w_unused_mode = ^iChMode;
  assign w_oneshot     = '0;
`endif

  assign w_tick = iEn && (r_pre_cnt == iPreDiv);
  assign w_acc  = r_evt_vld && iEvtReady;
  assign w_base = w_acc ? r_evt_ch : r_last;

  // A start or stop in the match cycle suppresses the fire; the channel is being re-armed or halted.
  always_comb begin
    w_match    = '0;
    w_fire     = '0;
    w_acc_mask = '0;
    w_ovr_set  = '0;
    for (int n = 0; n < pChNum; n++) begin
      w_match[n]    = (r_cnt[n] == r_shdw[n]);
      w_fire[n]     = r_busy[n] && w_tick && w_match[n] && !iChStop[n] && !iChStart[n];
      w_acc_mask[n] = w_acc && (r_evt_ch == 3'(n));
      w_ovr_set[n]  = w_fire[n] && r_pend[n] && !w_acc_mask[n];
    end
  end

  // Accepted channel drops out of the search unless it refires in the same cycle.
  assign w_cand = r_pend & ~(w_acc_mask & ~w_fire);

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = pChNum; i >= 1; i--) begin
      if (w_cand[(int'(w_base) + i) % pChNum]) begin
        w_found = 1'b1;
        w_sel   = 3'((int'(w_base) + i) % pChNum);
      end
    end
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      r_pre_cnt <= '0;
    end else if (iEn) begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      r_busy <= '0;
      for (int n = 0; n < pChNum; n++) begin
        r_cnt[n]  <= '0;
        r_shdw[n] <= '0;
      end
`ifdef CKE_SCHED_ONESHOT_EN
      r_mode <= '0;
`endif
    end else begin
      for (int n = 0; n < pChNum; n++) begin
        if (iChStop[n]) begin
          r_busy[n] <= 1'b0;
        end else if (iChStart[n]) begin
          r_busy[n] <= 1'b1;
          r_cnt[n]  <= '0;
          r_shdw[n] <= iChDiv[n*DW +: DW];
`ifdef CKE_SCHED_ONESHOT_EN
          r_mode[n] <= iChMode[n];
`endif
        end else if (r_busy[n] && w_tick) begin
          if (w_match[n]) begin
            r_cnt[n] <= '0;
            if (w_oneshot[n]) r_busy[n] <= 1'b0;
            else              r_shdw[n] <= iChDiv[n*DW +: DW];
          end else begin
            r_cnt[n] <= r_cnt[n] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      r_cke     <= '0;
      r_pend    <= '0;
      r_ovr     <= '0;
      r_last    <= 3'(pChNum - 1);
      r_evt_vld <= 1'b0;
      r_evt_ch  <= '0;
    end else begin
      r_cke  <= w_fire;
      r_pend <= (r_pend & ~w_acc_mask) | w_fire;
      r_ovr  <= (iOvrClr ? '0 : r_ovr) | w_ovr_set;
      if (w_acc) r_last <= r_evt_ch;
      // Presented event is held until accepted; only then is the next one picked.
      if (!r_evt_vld || w_acc) begin
        r_evt_vld <= w_found;
        r_evt_ch  <= w_sel;
      end
    end
  end

  assign oCke      = r_cke;
  assign oChBusy   = r_busy;
  assign oEvtValid = r_evt_vld;
  assign oEvtCh    = r_evt_ch;
  assign oChOvr    = r_ovr;

endmodule

// File: tb/tb_cke_sched.sv
// Self-checking bench for cke_sched: period table, arbiter ordering scoreboard, corner sequences.
module tb_cke_sched;
  localparam int NCH = 4;
  localparam int DW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, en, evt_rdy, ovr_clr, evt_vld;
  logic [DW-1:0]    pre_div;
  logic [NCH*DW-1:0] ch_div;
  logic [NCH-1:0]   ch_mode, ch_start, ch_stop, cke, busy, ovr;
  logic [2:0]       evt_ch;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  typedef struct {
    int pre;
    int div;
    int ch;
    int period;
  } vec_t;
  vec_t vecs[6];

  cke_sched #(.pChNum(NCH), .pDivWidth(DW-1)) dut (
    .iSysClk(clk), .iSysRst(rst_n), .iEn(en), .iPreDiv(pre_div), .iChDiv(ch_div),
    .iChMode(ch_mode), .iChStart(ch_start), .iChStop(ch_stop), .oCke(cke),
    .oChBusy(busy), .oEvtValid(evt_vld), .oEvtCh(evt_ch), .iEvtReady(evt_rdy),
    .oChOvr(ovr), .iOvrClr(ovr_clr)
  );

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b1; evt_rdy = 1'b1; ovr_clr = 1'b0;
    pre_div = '0; ch_div = '0; ch_mode = '0; ch_start = '0; ch_stop = '0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_div(input int ch, input int val);
    ch_div[ch*DW +: DW] = DW'(val);
  endtask

  task automatic start(input logic [NCH-1:0] m, output int t0);
    ch_start = m;
    step();
    ch_start = '0;
    t0 = cyc;
  endtask

  task automatic wait_cke(input int ch, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (cke[ch]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check($sformatf("timeout_cke%0d", ch), 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, first, last, seen;
    vecs[0] = '{pre: 0, div: 0, ch: 0, period: 1};
    vecs[1] = '{pre: 3, div: 4, ch: 1, period: 20};
    vecs[2] = '{pre: 1, div: 2, ch: 2, period: 6};
    vecs[3] = '{pre: 2, div: 0, ch: 3, period: 3};
    vecs[4] = '{pre: 0, div: 5, ch: 1, period: 6};
    vecs[5] = '{pre: 4, div: 1, ch: 0, period: 10};

    // Reset values
    apply_reset();
    check("rst_cke", cke, 0);
    check("rst_busy", busy, 0);
    check("rst_vld", evt_vld, 0);
    check("rst_ch", evt_ch, 0);
    check("rst_ovr", ovr, 0);

    // Period table: first-pulse latency window and steady period
    foreach (vecs[k]) begin
      apply_reset();
      pre_div = DW'(vecs[k].pre);
      set_div(vecs[k].ch, vecs[k].div);
      start(NCH'(1) << vecs[k].ch, t0);
      check($sformatf("busy_rise_v%0d", k), busy[vecs[k].ch], 1);
      wait_cke(vecs[k].ch, 200, t1);
      check($sformatf("first_lat_ok_v%0d", k),
            ((t1 - t0) >= vecs[k].div * (vecs[k].pre + 1) + 1) &&
            ((t1 - t0) <= (vecs[k].div + 1) * (vecs[k].pre + 1)), 1);
      wait_cke(vecs[k].ch, 200, t2);
      check($sformatf("period_v%0d", k), t2 - t1, vecs[k].period);
    end

    // Every-cycle pulses with continuous acceptance
    apply_reset();
    start(4'b0001, t0);
    step(); step(); step();
    for (int i = 0; i < 6; i++) begin
      check("cont_ch0", {cke[0], evt_vld, evt_ch}, 5'b11000);
      step();
    end

    // Divider change mid-period takes effect after the current period
    apply_reset();
    pre_div = 16'd3;
    set_div(1, 4);
    start(4'b0010, t0);
    wait_cke(1, 100, t1);
    wait_cke(1, 100, t2);
    check("p20_a", t2 - t1, 20);
    repeat (5) step();
    set_div(1, 1);
    wait_cke(1, 100, t3);
    wait_cke(1, 100, t4);
    check("p20_finish", t3 - t2, 20);
    check("p8_after", t4 - t3, 8);

    // One-shot channel (periodic when the option is compiled out)
    apply_reset();
    set_div(2, 2);
    ch_mode = 4'b0100;
    start(4'b0100, t0);
    wait_cke(2, 20, t1);
    check("oneshot_lat", t1 - t0, 3);
`ifdef CKE_SCHED_ONESHOT_EN
    check("oneshot_busy", busy[2], 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cke[2]) seen = 1;
    end
    check("oneshot_single", seen, 0);
`else
    wait_cke(2, 20, t2);
    check("oneshot_off_period", t2 - t1, 3);
    check("oneshot_off_busy", busy[2], 1);
`endif

    // Simultaneous fires drain round-robin from channel 0
    apply_reset();
    evt_rdy = 1'b0;
    for (int c = 0; c < NCH; c++) set_div(c, 30);
    start(4'b1111, t0);
    wait_cke(0, 60, t1);
    check("all_fire", cke, 4'b1111);
    repeat (10) step();
    check("held_vld", evt_vld, 1);
    check("held_ch", evt_ch, 0);
    for (int c = 0; c < NCH; c++) exp_q.push_back(c);
    evt_rdy = 1'b1;
    first = -1; last = -1;
    for (int i = 0; i < 15; i++) begin
      if (evt_vld && evt_rdy) begin
        if (exp_q.size() == 0) check("unexpected_evt", evt_ch, 7);
        else check("evt_order", evt_ch, exp_q.pop_front());
        if (first < 0) first = cyc;
        last = cyc;
      end
      step();
    end
    check("evt_drained", exp_q.size(), 0);
    check("evt_back2back", last - first, 3);
    check("no_ovr", ovr, 0);

    // Overrun on a second fire while pending, sticky until cleared
    apply_reset();
    evt_rdy = 1'b0;
    set_div(0, 3);
    start(4'b0001, t0);
    wait_cke(0, 20, t1);
    check("ovr_none_yet", ovr, 0);
    wait_cke(0, 20, t2);
    check("ovr_set", ovr, 4'b0001);
    ch_stop = 4'b0001;
    step();
    ch_stop = '0;
    repeat (3) step();
    check("ovr_sticky", ovr, 4'b0001);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_clr", ovr, 0);

    // Start and stop together: stop wins
    apply_reset();
    set_div(3, 2);
    ch_start = 4'b1000;
    ch_stop  = 4'b1000;
    step();
    ch_start = '0;
    ch_stop  = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (cke[3] || busy[3]) seen = 1;
      step();
    end
    check("startstop_idle", seen, 0);

    // Enable low stretches the period by exactly its length
    apply_reset();
    pre_div = 16'd3;
    set_div(1, 4);
    start(4'b0010, t0);
    wait_cke(1, 100, t1);
    repeat (5) step();
    en = 1'b0;
    repeat (50) step();
    en = 1'b1;
    wait_cke(1, 200, t2);
    check("en_stretch", t2 - t1, 70);

    // Asynchronous reset mid-run
    apply_reset();
    start(4'b0001, t0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {cke, busy, evt_vld, evt_ch, ovr}, 0);
    step(); step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cke != 0 || busy != 0) seen = 1;
    end
    check("post_rst_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
